// File: rtl/sdio_pkg.sv
// Shared encodings for the SDIO command sequencer: response types,
// sequencer states, status bit positions and frame bit positions.
package sdio_pkg;

    typedef enum logic [2:0] {
        RSP_NONE = 3'd0,  // no response expected
        RSP_R1   = 3'd1,  // R1/R6/R7: 48-bit, CRC checked
        RSP_R3   = 3'd2,  // R3: 48-bit, CRC field not checked
        RSP_R2   = 3'd3,  // R2: 136-bit CID/CSD
        RSP_R1B  = 3'd4   // R1b: 48-bit, CRC, then busy on DAT0
    } rsp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_RSP,
        ST_BUSY,
        ST_DONE
    } state_e;

    // Status bit positions
    localparam int STS_RSP_TIMEOUT  = 0;
    localparam int STS_CRC_ERR      = 1;
    localparam int STS_END_ERR      = 2;
    localparam int STS_TX_BIT_ERR   = 3;
    localparam int STS_BUSY_TIMEOUT = 4;

    // Command frame: 40 CRC-covered bits, then CRC7, then end bit
    localparam logic [7:0] TX_CRC_BITS = 8'd40;
    localparam logic [7:0] TX_LAST_BIT = 8'd47;

    // Response bit counter runs after the start bit has been seen
    localparam logic [7:0] RX_LAST_SHORT     = 8'd46;   // 47 bits after start
    localparam logic [7:0] RX_LAST_LONG      = 8'd134;  // 135 bits after start
    localparam logic [7:0] RX_CRC_END_SHORT  = 8'd39;   // frame bits 46..8
    localparam logic [7:0] RX_CRC_FIRST_LONG = 8'd7;    // frame bit 127
    localparam logic [7:0] RX_CRC_LAST_LONG  = 8'd126;  // frame bit 8

    // Cycles after the end bit during which the CMD line is not sampled
    localparam int TURNAROUND = 2;

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, initial value 0), one bit per enabled cycle.
module sdio_crc7 (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       d_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    assign fb    = d_i ^ crc_q[6];
    assign crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    assign crc_o = crc_q;

    // CRC register: clear wins over shift
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn_i) begin
            crc_q <= 7'd0;
        end else if (clr_i) begin
            crc_q <= 7'd0;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/sdio_cmd_seq.sv
// SD/SDIO CMD-line sequencer: sends one 48-bit command, optionally receives
// and checks the response, waits out R1b busy, and reports completion status.
module sdio_cmd_seq
    import sdio_pkg::*;
#(
    parameter int RSP_TIMEOUT  = 64,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         cfg_start_i,
    input  logic [5:0]   cfg_cmd_op_i,
    input  logic [31:0]  cfg_cmd_arg_i,
    input  logic [2:0]   cfg_cmd_rsp_type_i,
    input  logic         sdio_cmd_i,
    input  logic         sdio_data0_i,
    output logic         sdio_cmd_o,
    output logic         sdio_cmd_oen_o,
    output logic [127:0] rsp_data_o,
    output logic         busy_o,
    output logic         eot_o,
    output logic         err_o,
    output logic [15:0]  status_o
);

    localparam int TMR_MAX = (RSP_TIMEOUT > BUSY_TIMEOUT) ? RSP_TIMEOUT : BUSY_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_e       state_q, state_d;
    rsp_type_e    type_q, type_d;
    logic [39:0]  tx_q, tx_d;          // start, transmit, index, argument
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [133:0] rx_q, rx_d;          // response bits after the start bit
    logic [127:0] rsp_data_q, rsp_data_d;
    logic [15:0]  status_q, status_d;

    logic         crc_clr, crc_en, crc_din;
    logic [6:0]   crc_val;
    logic [7:0]   crc_sel;
    logic [134:0] rx_full;
    logic         is_r2, tx_bit_err, end_err, crc_err;
    logic [127:0] rsp_capture;
    logic [5:0]   rsp_index;

    sdio_crc7 u_crc7 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .d_i    (crc_din),
        .crc_o  (crc_val)
    );

    // Response decode on the final received bit (still on the CMD input)
    assign crc_sel     = 8'd46 - bit_cnt_q;
    assign rx_full     = {rx_q, sdio_cmd_i};
    assign is_r2       = (type_q == RSP_R2);
    assign tx_bit_err  = is_r2 ? rx_full[134] : rx_full[46];
    assign end_err     = ~rx_full[0];
    assign crc_err     = (type_q != RSP_R3) && (crc_val != rx_full[7:1]);
    assign rsp_capture = is_r2 ? {rx_full[127:1], 1'b0} : {90'd0, rx_full[45:8]};
    assign rsp_index   = is_r2 ? rx_full[133:128] : rx_full[45:40];

    assign busy_o     = (state_q != ST_IDLE);
    assign rsp_data_o = rsp_data_q;
    assign status_o   = status_q;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: datapath registers are reset too, so an aborted command leaves no stale payload or status.
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            type_q     <= RSP_NONE;
            tx_q       <= '0;
            bit_cnt_q  <= '0;
            tmr_q      <= '0;
            rx_q       <= '0;
            rsp_data_q <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            tx_q       <= tx_d;
            bit_cnt_q  <= bit_cnt_d;
            tmr_q      <= tmr_d;
            rx_q       <= rx_d;
            rsp_data_q <= rsp_data_d;
            status_q   <= status_d;
        end
    end

    // Next-state, datapath updates and CMD/pulse outputs
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        type_d         = type_q;
        tx_d           = tx_q;
        bit_cnt_d      = bit_cnt_q;
        tmr_d          = tmr_q;
        rx_d           = rx_q;
        rsp_data_d     = rsp_data_q;
        status_d       = status_q;
        crc_clr        = 1'b0;
        crc_en         = 1'b0;
        crc_din        = 1'b0;
        sdio_cmd_o     = 1'b1;
        sdio_cmd_oen_o = 1'b1;
        eot_o          = 1'b0;
        err_o          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    type_d     = rsp_type_e'(cfg_cmd_rsp_type_i);
                    tx_d       = {1'b0, 1'b1, cfg_cmd_op_i, cfg_cmd_arg_i};
                    bit_cnt_d  = '0;
                    status_d   = '0;
                    rsp_data_d = '0;
                    crc_clr    = 1'b1;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                sdio_cmd_oen_o = 1'b0;
                if (bit_cnt_q < TX_CRC_BITS) begin
                    sdio_cmd_o = tx_q[39];
                    crc_en     = 1'b1;
                    crc_din    = tx_q[39];
                    tx_d       = {tx_q[38:0], 1'b0};
                end else if (bit_cnt_q < TX_LAST_BIT) begin
                    sdio_cmd_o = crc_val[crc_sel[2:0]];
                end
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q == TX_LAST_BIT) begin
                    bit_cnt_d = '0;
                    tmr_d     = '0;
                    state_d   = (type_q == RSP_NONE) ? ST_DONE : ST_WAIT_RSP;
                end
            end

            // Lasts at most RSP_TIMEOUT cycles; the start bit itself is consumed here
            ST_WAIT_RSP: begin
                crc_clr   = 1'b1;
                bit_cnt_d = '0;
                if (tmr_q >= TMR_W'(TURNAROUND) && !sdio_cmd_i) begin
                    state_d = ST_RSP;
                end else if (tmr_q == TMR_W'(RSP_TIMEOUT - 1)) begin
                    status_d[STS_RSP_TIMEOUT] = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            // The zero start bit leaves a zero CRC unchanged, so CRC starts at the transmit bit
            ST_RSP: begin
                rx_d      = rx_full[133:0];
                bit_cnt_d = bit_cnt_q + 8'd1;
                crc_din   = sdio_cmd_i;
                crc_en    = is_r2 ? (bit_cnt_q >= RX_CRC_FIRST_LONG && bit_cnt_q <= RX_CRC_LAST_LONG)
                                  : (bit_cnt_q < RX_CRC_END_SHORT);
                if (bit_cnt_q == (is_r2 ? RX_LAST_LONG : RX_LAST_SHORT)) begin
                    rsp_data_d                = rsp_capture;
                    status_d[15:8]            = {2'b00, rsp_index};
                    status_d[STS_CRC_ERR]     = crc_err;
                    status_d[STS_END_ERR]     = end_err;
                    status_d[STS_TX_BIT_ERR]  = tx_bit_err;
                    tmr_d                     = '0;
                    if (type_q == RSP_R1B && !(crc_err || end_err || tx_bit_err)) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_BUSY: begin
                if (sdio_data0_i) begin
                    state_d = ST_DONE;
                end else if (tmr_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    status_d[STS_BUSY_TIMEOUT] = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_DONE: begin
                eot_o   = (status_q[4:0] == 5'd0);
                err_o   = (status_q[4:0] != 5'd0);
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdio_cmd_seq.sv
// Directed bench for sdio_cmd_seq: command framing, R7/R2/R3/R1b responses,
// timeouts, ignored restart and mid-response reset.
module tb_sdio_cmd_seq;

    localparam int RSP_TO  = 64;
    localparam int BUSY_TO = 300;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         cfg_start_i;
    logic [5:0]   cfg_cmd_op_i;
    logic [31:0]  cfg_cmd_arg_i;
    logic [2:0]   cfg_cmd_rsp_type_i;
    logic         sdio_cmd_i;
    logic         sdio_data0_i;
    logic         sdio_cmd_o;
    logic         sdio_cmd_oen_o;
    logic [127:0] rsp_data_o;
    logic         busy_o;
    logic         eot_o;
    logic         err_o;
    logic [15:0]  status_o;

    int checks = 0;
    int errors = 0;

    sdio_cmd_seq #(
        .RSP_TIMEOUT  (RSP_TO),
        .BUSY_TIMEOUT (BUSY_TO)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cfg_start_i        (cfg_start_i),
        .cfg_cmd_op_i       (cfg_cmd_op_i),
        .cfg_cmd_arg_i      (cfg_cmd_arg_i),
        .cfg_cmd_rsp_type_i (cfg_cmd_rsp_type_i),
        .sdio_cmd_i         (sdio_cmd_i),
        .sdio_data0_i       (sdio_data0_i),
        .sdio_cmd_o         (sdio_cmd_o),
        .sdio_cmd_oen_o     (sdio_cmd_oen_o),
        .rsp_data_o         (rsp_data_o),
        .busy_o             (busy_o),
        .eot_o              (eot_o),
        .err_o              (err_o),
        .status_o           (status_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reference CRC7 over the n low bits of data, MSB first
    function automatic logic [6:0] crc7(input logic [127:0] data, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Issue a command and capture the 48 CMD bits; optionally pulse start again mid-frame
    task automatic send_cmd(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rtype,
                            input int restart_at, output logic [47:0] frame, output logic oen_ok);
        cfg_cmd_op_i       = op;
        cfg_cmd_arg_i      = arg;
        cfg_cmd_rsp_type_i = rtype;
        cfg_start_i        = 1'b1;
        tick;
        cfg_start_i = 1'b0;
        oen_ok      = 1'b1;
        frame       = '0;
        for (int i = 0; i < 48; i++) begin
            if (i == restart_at) begin
                cfg_start_i        = 1'b1;
                cfg_cmd_op_i       = 6'd55;
                cfg_cmd_arg_i      = 32'hDEADBEEF;
                cfg_cmd_rsp_type_i = 3'd0;
            end else begin
                cfg_start_i = 1'b0;
            end
            if (sdio_cmd_oen_o !== 1'b0 || busy_o !== 1'b1) oen_ok = 1'b0;
            frame = {frame[46:0], sdio_cmd_o};
            tick;
        end
        cfg_start_i = 1'b0;
        if (sdio_cmd_oen_o !== 1'b1) oen_ok = 1'b0;
    endtask

    // Card model: after a short turnaround, drive the first nsend bits of an nbits frame
    task automatic drive_rsp(input logic [135:0] bits, input int nbits, input int nsend);
        sdio_cmd_i = 1'b1;
        repeat (4) tick;
        for (int i = 0; i < nsend; i++) begin
            sdio_cmd_i = bits[nbits - 1 - i];
            tick;
        end
        sdio_cmd_i = 1'b1;
    endtask

    // Bounded wait for a completion pulse; cycles counts ticks waited
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!(eot_o === 1'b1 || err_o === 1'b1) && cycles < limit) begin
            tick;
            cycles++;
        end
    endtask

    logic [47:0]  frame;
    logic         ok;
    int           cyc;
    logic [37:0]  r7_body;
    logic [47:0]  r7;
    logic [37:0]  r1b_body;
    logic [47:0]  r1b;
    logic [119:0] cid_body;
    logic [6:0]   cid_crc_bad;
    logic [135:0] r2;
    logic [47:0]  r3;
    logic         hold_ok;

    initial begin
        rstn_i             = 1'b0;
        cfg_start_i        = 1'b0;
        cfg_cmd_op_i       = '0;
        cfg_cmd_arg_i      = '0;
        cfg_cmd_rsp_type_i = '0;
        sdio_cmd_i         = 1'b1;
        sdio_data0_i       = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // Reset state
        check("rst_cmd", sdio_cmd_o, 1);
        check("rst_oen", sdio_cmd_oen_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_pulses", {eot_o, err_o}, 0);
        check("rst_status", status_o, 0);
        check("rst_rsp", rsp_data_o, 0);
        rstn_i = 1'b1;
        tick;

        // CMD0, no response
        send_cmd(6'd0, 32'h0, 3'd0, -1, frame, ok);
        check("cmd0_frame", frame, 48'h400000000095);
        check("cmd0_oen", ok, 1);
        wait_done(4, cyc);
        check("cmd0_eot", {eot_o, err_o}, 2'b10);
        check("cmd0_lat", cyc, 0);
        check("cmd0_status", status_o, 0);
        tick;
        check("cmd0_idle", {eot_o, err_o, busy_o}, 0);

        // CMD8 with a correct R7
        send_cmd(6'd8, 32'h000001AA, 3'd1, -1, frame, ok);
        check("cmd8_frame", frame, 48'h48000001AA87);
        check("cmd8_oen", ok, 1);
        r7_body = {6'd8, 32'h000001AA};
        r7 = {2'b00, r7_body, crc7({88'd0, 2'b00, r7_body}, 40), 1'b1};
        drive_rsp({88'd0, r7}, 48, 48);
        wait_done(4, cyc);
        check("r7_eot", {eot_o, err_o}, 2'b10);
        check("r7_lat", cyc, 0);
        check("r7_status", status_o, 16'h0800);
        check("r7_data", rsp_data_o, {90'd0, r7_body});
        tick;
        check("r7_idle", {eot_o, err_o, busy_o}, 0);

        // No response: CMD line stays high
        send_cmd(6'd8, 32'h000001AA, 3'd1, -1, frame, ok);
        wait_done(RSP_TO + 10, cyc);
        check("to_err", {eot_o, err_o}, 2'b01);
        check("to_lat", cyc, RSP_TO);
        check("to_status", status_o, 16'h0001);
        check("to_data", rsp_data_o, 0);
        tick;

        // CMD2 with an R2 whose CRC has one bit flipped
        send_cmd(6'd2, 32'h0, 3'd3, -1, frame, ok);
        cid_body    = 120'h0123456789ABCDEFFEDCBA98765432;
        cid_crc_bad = crc7({8'd0, cid_body}, 120) ^ 7'h04;
        r2 = {2'b00, 6'h3F, cid_body, cid_crc_bad, 1'b1};
        drive_rsp(r2, 136, 136);
        wait_done(4, cyc);
        check("r2_err", {eot_o, err_o}, 2'b01);
        check("r2_status", status_o, 16'h3F02);
        check("r2_data", rsp_data_o, {cid_body, cid_crc_bad, 1'b0});
        tick;

        // CMD41 with an R3: CRC field is all ones and must not be checked
        send_cmd(6'd41, 32'h40FF8000, 3'd2, -1, frame, ok);
        r3 = {2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1};
        drive_rsp({88'd0, r3}, 48, 48);
        wait_done(4, cyc);
        check("r3_eot", {eot_o, err_o}, 2'b10);
        check("r3_status", status_o, 16'h3F00);
        check("r3_data", rsp_data_o, {90'd0, 6'h3F, 32'h80FF8000});
        tick;

        // CMD7 R1b with DAT0 low for 100 cycles after the response
        send_cmd(6'd7, 32'h12340000, 3'd4, -1, frame, ok);
        r1b_body = {6'd7, 32'h00000900};
        r1b = {2'b00, r1b_body, crc7({88'd0, 2'b00, r1b_body}, 40), 1'b1};
        sdio_data0_i = 1'b0;
        drive_rsp({88'd0, r1b}, 48, 48);
        hold_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (busy_o !== 1'b1 || eot_o !== 1'b0 || err_o !== 1'b0) hold_ok = 1'b0;
            tick;
        end
        check("r1b_busy_hold", hold_ok, 1);
        sdio_data0_i = 1'b1;
        tick;
        check("r1b_eot", {eot_o, err_o}, 2'b10);
        check("r1b_status", status_o, 16'h0700);
        check("r1b_data", rsp_data_o, {90'd0, r1b_body});
        tick;
        check("r1b_idle", {eot_o, err_o, busy_o}, 0);

        // R1b with DAT0 never released
        send_cmd(6'd7, 32'h12340000, 3'd4, -1, frame, ok);
        sdio_data0_i = 1'b0;
        drive_rsp({88'd0, r1b}, 48, 48);
        wait_done(BUSY_TO + 10, cyc);
        check("bto_err", {eot_o, err_o}, 2'b01);
        check("bto_lat", cyc, BUSY_TO);
        check("bto_status", status_o, 16'h0710);
        sdio_data0_i = 1'b1;
        tick;

        // Second start during SEND is ignored; reset asserted mid-response
        send_cmd(6'd8, 32'h000001AA, 3'd1, 10, frame, ok);
        check("restart_frame", frame, 48'h48000001AA87);
        drive_rsp({88'd0, r7}, 48, 20);
        #2;
        rstn_i = 1'b0;
        #1;
        check("abort_cmd", {sdio_cmd_o, sdio_cmd_oen_o}, 2'b11);
        check("abort_busy", busy_o, 0);
        check("abort_pulses", {eot_o, err_o}, 0);
        check("abort_status", status_o, 0);
        check("abort_rsp", rsp_data_o, 0);
        tick;
        rstn_i  = 1'b1;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (eot_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) hold_ok = 1'b0;
            tick;
        end
        check("abort_quiet", hold_ok, 1);

        // Recovery after the abort
        send_cmd(6'd0, 32'h0, 3'd0, -1, frame, ok);
        check("recover_frame", frame, 48'h400000000095);
        wait_done(4, cyc);
        check("recover_eot", {eot_o, err_o}, 2'b10);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
